// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared FSM states, MIPS opcode/funct constants and ALU helpers for mc_core
package mc_pkg;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXEC    = 4'd6,
        ALUWB   = 4'd7,
        ADDI_EX = 4'd8,
        ADDI_WB = 4'd9,
        BRANCH  = 4'd10,
        JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'd0,
        ALU_SUB  = 3'd1,
        ALU_AND  = 3'd2,
        ALU_OR   = 3'd3,
        ALU_SLT  = 3'd4,
        ALU_NONE = 3'd7
    } alu_op_t;

    // ALU_NONE marks an R-type funct the core does not implement; DECODE turns it into a NOP
    function automatic alu_op_t funct_to_alu(input logic [5:0] funct);
        case (funct)
            FN_ADD:  return ALU_ADD;
            FN_SUB:  return ALU_SUB;
            FN_AND:  return ALU_AND;
            FN_OR:   return ALU_OR;
            FN_SLT:  return ALU_SLT;
            default: return ALU_NONE;
        endcase
    endfunction

    function automatic logic [31:0] alu_calc(input alu_op_t op, input logic [31:0] a,
                                             input logic [31:0] b);
        case (op)
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_SLT: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] sext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/mc_regfile.sv
// rtl/mc_regfile.sv - 32x32 register file, two async read ports, one sync write port, r0 reads 0
module mc_regfile (
    input  logic        clk,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2
);

    logic [31:0] regs [32];

    // No reset: contents survive a core reset; r0 is never written
    always_ff @(posedge clk) begin
        if (we && (waddr != 5'd0)) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata1 = (raddr1 == 5'd0) ? 32'd0 : regs[raddr1];
    assign rdata2 = (raddr2 == 5'd0) ? 32'd0 : regs[raddr2];

endmodule

// File: rtl/mc_core.sv
// rtl/mc_core.sv - multicycle MIPS subset core with shared memory port and GPIO register
// Optional memory-mapped GPIO store/load path enabled by defining MC_CORE_GPIO_EN.
module mc_core
    import mc_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0040_0000,
    parameter logic [31:0] GPIO_ADDR = 32'h0000_7FFC,
    parameter int          GPIO_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [31:0]       mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic [GPIO_W-1:0] GPIO_o,
    output logic [3:0]        state_o
);

    state_t      state, state_nx;
    logic [31:0] pc, ir, a, b, alu_out, mdr;
    logic [31:0] rf_rdata1, rf_rdata2, rf_wdata, gpio_zext;
    logic [4:0]  rf_waddr;
    logic        rf_we, gpio_hit;

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;

    assign opcode = ir[31:26];
    assign rs     = ir[25:21];
    assign rt     = ir[20:16];
    assign rd     = ir[15:11];
    assign imm    = ir[15:0];
    assign funct  = ir[5:0];

`ifdef MC_CORE_GPIO_EN
    localparam logic GPIO_EN = 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            GPIO_o <= '0;
        end else if ((state == MEMWR) && gpio_hit) begin
            GPIO_o <= b[GPIO_W-1:0];
        end
    end
`else
    localparam logic GPIO_EN = 1'b0;

    assign GPIO_o = '0;
`endif

    assign gpio_hit = GPIO_EN && (alu_out == GPIO_ADDR);

    always_comb begin
        gpio_zext = '0;
        gpio_zext[GPIO_W-1:0] = GPIO_o;
    end

    mc_regfile u_regfile (
        .clk    (clk),
        .we     (rf_we),
        .waddr  (rf_waddr),
        .wdata  (rf_wdata),
        .raddr1 (rs),
        .raddr2 (rt),
        .rdata1 (rf_rdata1),
        .rdata2 (rf_rdata2)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FETCH;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            FETCH:   if (mem_ready) state_nx = DECODE;
            DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_nx = MEMADR;
                    OP_RTYPE:     state_nx = (funct_to_alu(funct) != ALU_NONE) ? EXEC : FETCH;
                    OP_ADDI:      state_nx = ADDI_EX;
                    OP_BEQ:       state_nx = BRANCH;
                    OP_J:         state_nx = JUMP;
                    default:      state_nx = FETCH;
                endcase
            end
            MEMADR:  state_nx = (opcode == OP_LW) ? MEMRD : MEMWR;
            MEMRD:   if (gpio_hit || mem_ready) state_nx = MEMWB;
            MEMWB:   state_nx = FETCH;
            MEMWR:   if (gpio_hit || mem_ready) state_nx = FETCH;
            EXEC:    state_nx = ALUWB;
            ALUWB:   state_nx = FETCH;
            ADDI_EX: state_nx = ADDI_WB;
            ADDI_WB: state_nx = FETCH;
            BRANCH:  state_nx = FETCH;
            JUMP:    state_nx = FETCH;
            default: state_nx = FETCH;
        endcase
    end

    // mem_req is gated by reset so an asserted reset drops an access in the same cycle
    always_comb begin
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        mem_addr = {pc[31:2], 2'b00};
        rf_we    = 1'b0;
        rf_waddr = rt;
        rf_wdata = alu_out;
        case (state)
            FETCH: mem_req = reset;
            MEMRD: begin
                mem_req  = reset && !gpio_hit;
                mem_addr = {alu_out[31:2], 2'b00};
            end
            MEMWR: begin
                mem_req  = reset && !gpio_hit;
                mem_we   = !gpio_hit;
                mem_addr = {alu_out[31:2], 2'b00};
            end
            MEMWB: begin
                rf_we    = 1'b1;
                rf_wdata = mdr;
            end
            ALUWB: begin
                rf_we    = 1'b1;
                rf_waddr = rd;
            end
            ADDI_WB: rf_we = 1'b1;
            default: ;
        endcase
    end

    assign mem_wdata = b;
    assign state_o   = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc      <= RESET_PC;
            ir      <= 32'd0;
            a       <= 32'd0;
            b       <= 32'd0;
            alu_out <= 32'd0;
            mdr     <= 32'd0;
        end else begin
            case (state)
                FETCH: begin
                    if (mem_ready) begin
                        ir <= mem_rdata;
                        pc <= pc + 32'd4;
                    end
                end
                DECODE: begin
                    a       <= rf_rdata1;
                    b       <= rf_rdata2;
                    alu_out <= pc + (sext16(imm) << 2);
                end
                MEMADR, ADDI_EX: alu_out <= a + sext16(imm);
                MEMRD: begin
                    if (gpio_hit) begin
                        mdr <= gpio_zext;
                    end else if (mem_ready) begin
                        mdr <= mem_rdata;
                    end
                end
                EXEC:   alu_out <= alu_calc(funct_to_alu(funct), a, b);
                BRANCH: if (a == b) pc <= alu_out;
                JUMP:   pc <= {pc[31:28], ir[25:0], 2'b00};
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_core.sv
// tb/tb_mc_core.sv - scoreboard bench for mc_core: directed MIPS program, memory model, store monitor
module tb_mc_core;

    localparam logic [3:0] ST_FETCH = 4'd0;
    localparam logic [3:0] ST_MEMWR = 4'd5;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mem_req, mem_we, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0]  GPIO_o;
    logic [3:0]  state_o;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int data_delay = 0;
    int wcnt = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] mem [int unsigned];

    mc_core dut (
        .clk       (clk),
        .reset     (reset),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .GPIO_o    (GPIO_o),
        .state_o   (state_o)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd,
                                          input logic [5:0] fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt,
                                          input logic [15:0] imm);
        return {op, 5'(rs), 5'(rt), imm};
    endfunction

    function automatic logic [31:0] rd_mem(input logic [31:0] addr);
        int unsigned k;
        k = addr >> 2;
        return mem.exists(k) ? mem[k] : 32'd0;
    endfunction

    function automatic void push_wr(input logic [31:0] addr, input logic [31:0] data);
        wr_t e;
        e.addr = addr;
        e.data = data;
        exp_q.push_back(e);
    endfunction

    // Memory responder: fetches complete at once, data accesses after data_delay wait cycles
    always @(negedge clk) begin : responder
        int d;
        d = (mem_addr >= 32'h0040_0000) ? 0 : data_delay;
        if (mem_req) begin
            if (wcnt >= d) begin
                mem_ready = 1'b1;
                wcnt = 0;
                if (mem_we) mem[mem_addr >> 2] = mem_wdata;
                else        mem_rdata = rd_mem(mem_addr);
            end else begin
                mem_ready = 1'b0;
                wcnt++;
            end
        end else begin
            mem_ready = 1'b0;
            wcnt = 0;
        end
    end

    // Store monitor and request-stability monitor
    logic        prev_stall = 1'b0;
    logic        p_we;
    logic [31:0] p_addr, p_wdata;

    always @(negedge clk) begin : monitor
        wr_t e;
        #1;
        if (reset && mem_req && mem_we && mem_ready) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_write: got write %h to %h, expected none", mem_wdata, mem_addr);
            end else begin
                e = exp_q.pop_front();
                check("store_addr", mem_addr, e.addr);
                check("store_data", mem_wdata, e.data);
            end
        end
        if (reset && prev_stall && mem_req) begin
            check("stable_addr", mem_addr, p_addr);
            check("stable_we", {31'd0, mem_we}, {31'd0, p_we});
            check("stable_wdata", mem_wdata, p_wdata);
        end
        prev_stall = reset && mem_req && !mem_ready;
        p_addr     = mem_addr;
        p_we       = mem_we;
        p_wdata    = mem_wdata;
    end

    task automatic wait_fetch(input logic [31:0] addr, output int at);
        at = -1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            #2;
            if (mem_req && !mem_we && (state_o == ST_FETCH) && (mem_addr == addr)) begin
                at = cyc;
                return;
            end
        end
        vectors++;
        miscompares++;
        $display("FAIL fetch_timeout: got no fetch of %h in 200 cycles, expected one", addr);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] prog [20];
        int t0, t1, t2, cnt, found;

        mem_ready = 1'b0;
        mem_rdata = 32'd0;

        prog[0]  = enc_i(6'h08, 0, 1, 16'd5);          // addi r1,r0,5
        prog[1]  = enc_i(6'h08, 0, 2, 16'd7);          // addi r2,r0,7
        prog[2]  = enc_r(1, 2, 3, 6'h20);              // add  r3,r1,r2
        prog[3]  = enc_i(6'h2B, 0, 3, 16'h7FFC);       // sw   r3,0x7FFC(r0)
        prog[4]  = enc_r(1, 2, 4, 6'h22);              // sub  r4,r1,r2
        prog[5]  = enc_i(6'h2B, 0, 4, 16'h0100);       // sw   r4,0x100
        prog[6]  = enc_r(4, 1, 5, 6'h2A);              // slt  r5,r4,r1
        prog[7]  = enc_i(6'h2B, 0, 5, 16'h0104);       // sw   r5,0x104
        prog[8]  = enc_r(1, 2, 6, 6'h24);              // and  r6,r1,r2
        prog[9]  = enc_r(1, 2, 7, 6'h25);              // or   r7,r1,r2
        prog[10] = enc_i(6'h2B, 0, 6, 16'h0108);       // sw   r6,0x108
        prog[11] = enc_i(6'h2B, 0, 7, 16'h010C);       // sw   r7,0x10C
        prog[12] = enc_i(6'h08, 0, 0, 16'd9);          // addi r0,r0,9
        prog[13] = enc_i(6'h2B, 0, 0, 16'h0118);       // sw   r0,0x118
        prog[14] = 32'hFC00_0000;                      // unsupported opcode
        prog[15] = enc_i(6'h23, 0, 8, 16'h0200);       // lw   r8,0x200
        prog[16] = enc_i(6'h2B, 0, 8, 16'h0110);       // sw   r8,0x110
        prog[17] = enc_i(6'h23, 0, 9, 16'h7FFC);       // lw   r9,0x7FFC
        prog[18] = enc_i(6'h2B, 0, 9, 16'h0114);       // sw   r9,0x114
        prog[19] = enc_i(6'h2B, 0, 7, 16'h0300);       // sw   r7,0x300 (stalled, reset)
        for (int i = 0; i < 20; i++) mem[32'h0010_0000 + i] = prog[i];
        mem[32'h0010_0040] = enc_i(6'h04, 1, 2, 16'd5);    // 0x400100 beq r1,r2,+5
        mem[32'h0010_0041] = enc_i(6'h04, 1, 1, 16'hFFFF); // 0x400104 beq r1,r1,-1
        mem[32'h200 >> 2]  = 32'hDEAD_BEEF;

`ifndef MC_CORE_GPIO_EN
        push_wr(32'h0000_7FFC, 32'h0000_000C);
`endif
        push_wr(32'h0000_0100, 32'hFFFF_FFFE);
        push_wr(32'h0000_0104, 32'h0000_0001);
        push_wr(32'h0000_0108, 32'h0000_0005);
        push_wr(32'h0000_010C, 32'h0000_0007);
        push_wr(32'h0000_0118, 32'h0000_0000);
        push_wr(32'h0000_0110, 32'hDEAD_BEEF);
        push_wr(32'h0000_0114, 32'h0000_000C);

        repeat (3) @(negedge clk);
        #2;
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_state", {28'd0, state_o}, 32'd0);
        check("rst_gpio", 32'(GPIO_o), 32'd0);
        reset = 1'b1;

        @(negedge clk);
        #2;
        check("first_req", {31'd0, mem_req}, 32'd1);
        check("first_addr", mem_addr, 32'h0040_0000);
        check("first_we", {31'd0, mem_we}, 32'd0);
        t0 = cyc;

        wait_fetch(32'h0040_000C, t1);
        check("three_instr_cycles", t1 - t0, 32'd12);
        repeat (3) begin @(negedge clk); #2; end
        check("sw_gpio_state", {28'd0, state_o}, {28'd0, ST_MEMWR});
`ifdef MC_CORE_GPIO_EN
        check("sw_gpio_no_req", {31'd0, mem_req}, 32'd0);
`else
        check("sw_gpio_req", {31'd0, mem_req}, 32'd1);
        check("sw_gpio_we", {31'd0, mem_we}, 32'd1);
        check("sw_gpio_addr", mem_addr, 32'h0000_7FFC);
`endif
        wait_fetch(32'h0040_0010, t2);
        check("sw_cycles", t2 - t1, 32'd4);
`ifdef MC_CORE_GPIO_EN
        check("gpio_value", 32'(GPIO_o), 32'h0000_000C);
`else
        check("gpio_value", 32'(GPIO_o), 32'd0);
`endif
        wait_fetch(32'h0040_0014, t1);
        check("rtype_cycles", t1 - t2, 32'd4);

        wait_fetch(32'h0040_0038, t0);
        data_delay = 3;
        wait_fetch(32'h0040_003C, t1);
        check("nop_cycles", t1 - t0, 32'd2);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #2;
            if (mem_req && (mem_addr == 32'h200)) cnt++;
            else if (cnt > 0) break;
        end
        check("lw_req_cycles", cnt, 32'd4);
        wait_fetch(32'h0040_0040, t2);
        check("lw_stalled_cycles", t2 - t1, 32'd8);

        wait_fetch(32'h0040_004C, t0);
        data_delay = 1000;
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            @(negedge clk);
            #2;
            if ((state_o == ST_MEMWR) && mem_req) found = 1;
        end
        check("stall_reached", found, 32'd1);
        repeat (2) begin @(negedge clk); #2; end
        #1;
        reset = 1'b0;
        #1;
        check("rst_mid_req", {31'd0, mem_req}, 32'd0);
        check("rst_mid_state", {28'd0, state_o}, 32'd0);
        check("rst_mid_gpio", 32'(GPIO_o), 32'd0);
        check("pending_writes", exp_q.size(), 32'd0);
        check("no_abandoned_write", {31'd0, mem.exists(32'h300 >> 2)}, 32'd0);

        data_delay = 0;
        mem[32'h0010_0000] = {6'h02, 26'h010_0040};      // j 0x400100
        repeat (2) @(negedge clk);
        #2;
        reset = 1'b1;
        @(negedge clk);
        #2;
        check("refetch_addr", mem_addr, 32'h0040_0000);
        t0 = cyc;
        wait_fetch(32'h0040_0100, t1);
        check("jump_cycles", t1 - t0, 32'd3);
        wait_fetch(32'h0040_0104, t2);
        check("beq_not_taken", t2 - t1, 32'd3);
        wait_fetch(32'h0040_0104, t1);
        check("beq_loop_1", t1 - t2, 32'd3);
        wait_fetch(32'h0040_0104, t2);
        check("beq_loop_2", t2 - t1, 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mc_core.md
MC_CORE -- requirements
Module: mc_core

Interface
REQ-001 The block SHALL have the parameter RESET_PC, default 32'h0040_0000, which is the PC value loaded on reset.
REQ-002 The block SHALL have the parameter GPIO_ADDR, default 32'h0000_7FFC, which is the word address of the GPIO output register.
REQ-003 The block SHALL have the parameter GPIO_W, default 8, which is the GPIO output width (1..32).
REQ-004 The block SHALL have the port clk, input, 1 bit: the single clock, rising edge.
REQ-005 The block SHALL have the port reset, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have the port mem_req, output, 1 bit: memory access request.
REQ-007 The block SHALL have the port mem_we, output, 1 bit: write enable, qualified by mem_req.
REQ-008 The block SHALL have the port mem_addr, output, 32 bits: byte address, always word-aligned.
REQ-009 The block SHALL have the port mem_wdata, output, 32 bits: store data.
REQ-010 The block SHALL have the port mem_rdata, input, 32 bits: load or fetch data, valid when mem_ready=1.
REQ-011 The block SHALL have the port mem_ready, input, 1 bit: access complete this cycle.
REQ-012 The block SHALL have the port GPIO_o, output, GPIO_W bits: registered GPIO output.
REQ-013 The block SHALL have the port state_o, output, 4 bits: current FSM state, for debug.

Function
REQ-014 The block SHALL implement a multicycle MIPS subset: add, sub, and, or, slt (R-type, funct 0x20/0x22/0x24/0x25/0x2A), addi, lw, sw, beq and j, with standard MIPS encodings.
REQ-015 The FSM SHALL have the states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, ADDI_EX, ADDI_WB, BRANCH and JUMP, encoded in 4 bits.
REQ-016 In FETCH the block SHALL drive mem_req=1, mem_we=0 and mem_addr=PC, and hold them until mem_ready=1. On the ready edge it SHALL load IR with mem_rdata, set PC to PC+4, and go to DECODE.
REQ-017 In DECODE the block SHALL read rs and rt into A and B, compute ALUOut = PC + (sign-extended imm << 2), and dispatch on opcode.
REQ-018 An unsupported opcode or funct SHALL be executed as a NOP: DECODE goes to FETCH with no register, memory or GPIO write.
REQ-019 MEMADR SHALL compute ALUOut = A + sign-extended imm, then go to MEMRD (lw) or MEMWR (sw).
REQ-020 MEMRD and MEMWR SHALL hold mem_req until mem_ready=1; the number of wait cycles is unbounded.
REQ-021 The MEMRD to MEMWB transition SHALL capture mem_rdata into MDR; MEMWB SHALL write MDR to register rt.
REQ-022 A register write to r0 SHALL be discarded, and r0 SHALL always read as 0.
REQ-023 BRANCH SHALL load PC with ALUOut when A==B; otherwise PC is unchanged.
REQ-024 JUMP SHALL load PC with {PC[31:28], IR[25:0], 2'b00}.
REQ-025 All ALU arithmetic SHALL be 32-bit two's-complement with wrap-around and no overflow trap; slt SHALL compare signed operands.
REQ-026 Instruction latency with mem_ready tied high SHALL be: lw 5 cycles, sw 4, R-type 4, addi 4, beq 3, j 3.
REQ-027 mem_addr, mem_we and mem_wdata SHALL be stable throughout any cycle in which mem_req=1.

Reset
REQ-028 Asserting reset (reset=0) SHALL asynchronously set PC to RESET_PC, IR, A, B, ALUOut and MDR to 0, GPIO_o to 0, mem_req to 0, and the state to FETCH.
REQ-029 A reset asserted mid-access SHALL abandon the access immediately, with no register or GPIO write.
REQ-030 Register file contents SHALL not be cleared by reset, except r0, which is 0 by construction.
REQ-031 After reset is released, the first FETCH request SHALL appear in the first cycle.

Configuration
REQ-032 When the macro MC_CORE_GPIO_EN is defined, a sw whose address equals GPIO_ADDR SHALL update GPIO_o with B[GPIO_W-1:0] in MEMWR in one cycle, SHALL not assert mem_req, and SHALL not wait for mem_ready.
REQ-033 When MC_CORE_GPIO_EN is defined, a lw from GPIO_ADDR SHALL return the zero-extended GPIO_o without asserting mem_req.
REQ-034 When MC_CORE_GPIO_EN is undefined, GPIO_o SHALL be tied to 0, and every access, including GPIO_ADDR, SHALL go to the memory port.

Structure
REQ-035 The shared package mc_pkg SHALL hold the state enum, the opcode and funct constants, and the ALU operation codes.
REQ-036 The block SHALL have exactly one sub-module, mc_regfile: 32x32, two asynchronous read ports, one synchronous write port, r0 hard-wired to 0.

Verification
REQ-037 Reset then release with mem_ready=1 -> mem_addr=0x0040_0000 and mem_req=1 in cycle 1, GPIO_o=0.
REQ-038 Run addi r1,r0,5; addi r2,r0,7; add r3,r1,r2 -> r3=12 after 12 cycles.
REQ-039 Run sw r3,0x7FFC(r0) with MC_CORE_GPIO_EN defined -> GPIO_o=0x0C and no mem_req during MEMWR; with the macro undefined -> mem_we=1 at address 0x7FFC.
REQ-040 Run lw with mem_ready delayed 3 cycles -> request held stable for 4 cycles and the rt value written after ready.
REQ-041 Run beq r1,r1,-1 -> PC returns to the same instruction (loop); with r1!=r2 -> PC+4.
REQ-042 Assert reset during a stalled MEMWR -> mem_req=0 immediately, the state is FETCH, and no write occurs.
